// File: rtl/aldffe_stim_seq.sv
// Stimulus sequencer for an async-load, enable-gated register: PRE, LOAD0, GAP, LOAD1, RUN, DONE.
// Define ALDSEQ_LFSR_EN to drive d from a Fibonacci LFSR instead of a plain toggle.
module aldffe_stim_seq #(
  parameter int               WIDTH    = 4,
  parameter logic [WIDTH-1:0] AD_VALUE = WIDTH'(4'b1010),
  parameter int               T_PRE    = 2,
  parameter int               T_LOAD   = 1,
  parameter int               T_GAP    = 2,
  parameter int               T_RUN    = 5
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  output logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] ad,
  output logic             aload,
  output logic             en,
  output logic             busy,
  output logic             done,
  output logic [2:0]       phase
);

  // A zero-length phase would never exit cleanly, so it is stretched to one cycle.
  localparam int TP = (T_PRE  < 1) ? 1 : T_PRE;
  localparam int TL = (T_LOAD < 1) ? 1 : T_LOAD;
  localparam int TG = (T_GAP  < 1) ? 1 : T_GAP;
  localparam int TR = (T_RUN  < 1) ? 1 : T_RUN;

  localparam int TMAX_A = (TP > TL) ? TP : TL;
  localparam int TMAX_B = (TG > TR) ? TG : TR;
  localparam int TMAX   = (TMAX_A > TMAX_B) ? TMAX_A : TMAX_B;
  localparam int CW     = (TMAX < 2) ? 1 : $clog2(TMAX);

  localparam logic [CW-1:0] C_PRE  = CW'(TP - 1);
  localparam logic [CW-1:0] C_LOAD = CW'(TL - 1);
  localparam logic [CW-1:0] C_GAP  = CW'(TG - 1);
  localparam logic [CW-1:0] C_RUN  = CW'(TR - 1);

`ifdef ALDSEQ_LFSR_EN
  localparam logic [WIDTH-1:0] D_RST = '1;
`else
  localparam logic [WIDTH-1:0] D_RST = '0;
`endif

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_PRE   = 3'd1,
    S_LOAD0 = 3'd2,
    S_GAP   = 3'd3,
    S_LOAD1 = 3'd4,
    S_RUN   = 3'd5,
    S_DONE  = 3'd6,
    S_BAD   = 3'd7
  } state_t;

  state_t           r_state;
  state_t           w_state_nxt;
  logic [CW-1:0]    r_cnt;
  logic [CW-1:0]    w_cnt_nxt;
  logic [WIDTH-1:0] r_d;
  logic [WIDTH-1:0] r_ad;
  logic             r_aload;
  logic             r_en;
  logic             r_busy;
  logic             r_done;

  function automatic logic f_aload(input state_t s);
    return (s == S_LOAD0) || (s == S_LOAD1);
  endfunction

  function automatic logic f_en(input state_t s);
    return (s == S_LOAD1) || (s == S_RUN);
  endfunction

  function automatic logic f_busy(input state_t s);
    return (s == S_PRE) || (s == S_LOAD0) || (s == S_GAP) ||
           (s == S_LOAD1) || (s == S_RUN);
  endfunction

  function automatic logic [WIDTH-1:0] f_next_d(input logic [WIDTH-1:0] v);
`ifdef ALDSEQ_LFSR_EN
    return {v[WIDTH-2:0], v[WIDTH-1] ^ v[WIDTH-2]};
`else
    return ~v;
`endif
  endfunction

  // Next-state: each timed phase exits on the edge where its counter has reached zero.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_PRE;
          w_cnt_nxt   = C_PRE;
        end
      end
      S_PRE: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_LOAD0;
          w_cnt_nxt   = C_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_LOAD0: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_GAP;
          w_cnt_nxt   = C_GAP;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_GAP: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_LOAD1;
          w_cnt_nxt   = C_LOAD;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_LOAD1: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_RUN;
          w_cnt_nxt   = C_RUN;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_RUN: begin
        if (r_cnt == '0) begin
          w_state_nxt = S_DONE;
          w_cnt_nxt   = '0;
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
        end
      end
      S_DONE: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // Outputs are decoded from the next state so they line up with phase in the same cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_d     <= D_RST;
      r_ad    <= AD_VALUE;
      r_aload <= 1'b0;
      r_en    <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_ad    <= AD_VALUE;
      r_aload <= f_aload(w_state_nxt);
      r_en    <= f_en(w_state_nxt);
      r_busy  <= f_busy(w_state_nxt);
      r_done  <= (w_state_nxt == S_DONE);
      if (f_busy(w_state_nxt)) begin
        r_d <= f_next_d(r_d);
      end
    end
  end

  assign d     = r_d;
  assign ad    = r_ad;
  assign aload = r_aload;
  assign en    = r_en;
  assign busy  = r_busy;
  assign done  = r_done;
  assign phase = r_state;

endmodule

// File: tb/tb_aldffe_stim_seq.sv
// Randomized self-checking bench for aldffe_stim_seq against a phase-program queue model.
module tb_aldffe_stim_seq;
  localparam int         W      = 4;
  localparam int         M_PRE  = 2;
  localparam int         M_LOAD = 1;
  localparam int         M_GAP  = 2;
  localparam int         M_RUN  = 5;
  localparam logic [3:0] AD_EXP = 4'b1010;
`ifdef ALDSEQ_LFSR_EN
  localparam logic [W-1:0] D_RST = 4'b1111;
`else
  localparam logic [W-1:0] D_RST = 4'b0000;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] d;
  logic [W-1:0] ad;
  logic         aload;
  logic         en;
  logic         busy;
  logic         done;
  logic [2:0]   phase;

  int checks = 0;
  int failures = 0;

  int           m_q[$];
  logic [2:0]   m_ph;
  logic [W-1:0] m_d;

  always #5 clk = ~clk;

  aldffe_stim_seq dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .d     (d),
    .ad    (ad),
    .aload (aload),
    .en    (en),
    .busy  (busy),
    .done  (done),
    .phase (phase)
  );

  function automatic logic [W-1:0] m_next(input logic [W-1:0] v);
`ifdef ALDSEQ_LFSR_EN
    logic [W-1:0] r;
    r = {v[W-2:0], v[W-1] ^ v[W-2]};
    return r;
`else
    return ~v;
`endif
  endfunction

  task automatic model_reset();
    m_q.delete();
    m_ph = 3'd0;
    m_d  = D_RST;
  endtask

  // The model plays back a program of phase values; idle only accepts start when empty.
  task automatic model_edge(input logic s);
    if (m_q.size() == 0 && m_ph == 3'd0 && s) begin
      for (int i = 0; i < M_PRE;  i++) m_q.push_back(1);
      for (int i = 0; i < M_LOAD; i++) m_q.push_back(2);
      for (int i = 0; i < M_GAP;  i++) m_q.push_back(3);
      for (int i = 0; i < M_LOAD; i++) m_q.push_back(4);
      for (int i = 0; i < M_RUN;  i++) m_q.push_back(5);
      m_q.push_back(6);
    end
    if (m_q.size() > 0) m_ph = 3'(m_q.pop_front());
    else                m_ph = 3'd0;
    if (m_ph >= 3'd1 && m_ph <= 3'd5) m_d = m_next(m_d);
  endtask

  function automatic logic [14:0] exp_vec();
    return {m_ph, m_d, AD_EXP,
            (m_ph == 3'd2 || m_ph == 3'd4),
            (m_ph == 3'd4 || m_ph == 3'd5),
            (m_ph >= 3'd1 && m_ph <= 3'd5),
            (m_ph == 3'd6)};
  endfunction

  function automatic logic [14:0] obs_vec();
    return {phase, d, ad, aload, en, busy, done};
  endfunction

  task automatic clk_edge();
    logic s;
    s = start;
    @(posedge clk);
    model_edge(s);
    #1;
  endtask

  task automatic test_reset();
    logic [14:0] rst_vec;
    rst_vec = {3'd0, D_RST, AD_EXP, 4'b0000};
    rst_n = 1'b0;
    model_reset();
    for (int i = 0; i < 4; i++) begin
      start = 1'($urandom_range(0, 1));
      @(posedge clk);
      #1;
      checks++;
      if (obs_vec() !== rst_vec) begin
        failures++;
        $display("FAIL reset_hold cyc=%0d got=%h want=%h", i, obs_vec(), rst_vec);
      end
    end
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      clk_edge();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL reset_idle cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_single_run();
    int tbl[13] = '{1, 1, 2, 3, 3, 4, 5, 5, 5, 5, 5, 6, 0};
    int busy_cnt = 0;
    start = 1'b1;
    for (int i = 0; i < 13; i++) begin
      clk_edge();
      start = 1'b0;
      if (busy === 1'b1) busy_cnt++;
      checks++;
      if (int'(phase) != tbl[i] || $isunknown(phase)) begin
        failures++;
        $display("FAIL single_phase edge=%0d got=%0d want=%0d", i + 1, phase, tbl[i]);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_outputs edge=%0d got=%h want=%h", i + 1, obs_vec(), exp_vec());
      end
    end
    checks++;
    if (busy_cnt != 11) begin
      failures++;
      $display("FAIL single_busy_len got=%0d want=11", busy_cnt);
    end
    for (int i = 0; i < 3; i++) begin
      clk_edge();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL single_idle_hold cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  task automatic test_back_to_back();
    int done_edge = -1;
    int pre_edge = -1;
    start = 1'b1;
    for (int i = 0; i < 30; i++) begin
      clk_edge();
      if (done === 1'b1 && done_edge < 0) done_edge = i;
      if (done_edge >= 0 && pre_edge < 0 && phase === 3'd1) pre_edge = i;
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL b2b_outputs cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    start = 1'b0;
    checks++;
    if (done_edge < 0 || pre_edge - done_edge != 2) begin
      failures++;
      $display("FAIL b2b_gap got=%0d want=2", pre_edge - done_edge);
    end
    for (int i = 0; i < 14; i++) clk_edge();
  endtask

  task automatic test_random();
    for (int i = 0; i < 200; i++) begin
      start = ($urandom_range(0, 3) == 0);
      clk_edge();
      checks++;
      if (obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL random_outputs cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
    start = 1'b0;
    for (int i = 0; i < 14; i++) clk_edge();
  endtask

  task automatic test_async_reset();
    logic [14:0] rst_vec;
    int          waited = 0;
    rst_vec = {3'd0, D_RST, AD_EXP, 4'b0000};
    start = 1'b1;
    clk_edge();
    start = 1'b0;
    while (phase !== 3'd5 && waited < 30) begin
      clk_edge();
      waited++;
    end
    checks++;
    if (phase !== 3'd5) begin
      failures++;
      $display("FAIL async_reach_run got=%0d want=5", phase);
    end
    clk_edge();
    @(negedge clk);
    rst_n = 1'b0;
    model_reset();
    #1;
    checks++;
    if (obs_vec() !== rst_vec) begin
      failures++;
      $display("FAIL async_immediate got=%h want=%h", obs_vec(), rst_vec);
    end
    clk_edge();
    checks++;
    if (obs_vec() !== rst_vec) begin
      failures++;
      $display("FAIL async_hold got=%h want=%h", obs_vec(), rst_vec);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      clk_edge();
      checks++;
      if (phase !== 3'd0 || obs_vec() !== exp_vec()) begin
        failures++;
        $display("FAIL async_release cyc=%0d got=%h want=%h", i, obs_vec(), exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_run();
    test_back_to_back();
    test_random();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/aldffe_stim_seq.md
Name: aldffe_stim_seq

Overview:
- Upstream stimulus sequencer that drives the d/ad/aload/en inputs of a WIDTH-bit async-load, enable-gated register (aldffe-style) under test.
- On start, it steps through a fixed phase program:
  - a load with enable low;
  - a gap;
  - a load with enable high;
  - an enabled run.
- It then pulses done.
- Phase lengths are parameterised. All outputs are registered, so the downstream register sees clean, glitch-free controls.

Parameters:
- WIDTH, 4, data width of d and ad (>=2).
- AD_VALUE, 4'b1010, constant async-load value driven on ad.
- T_PRE, 2, cycles in PRE phase.
- T_LOAD, 1, cycles aload is held high in each load phase.
- T_GAP, 2, cycles in GAP phase.
- T_RUN, 5, cycles in RUN phase.
- Any T_* parameter of 0 is treated as 1.

Ports:
- clk  input  1  clock; all state changes on rising edge.
- rst_n  input  1  reset, asynchronous, active-low.
- start  input  1  begin a sequence; sampled only in IDLE.
- d  output  WIDTH  data stimulus.
- ad  output  WIDTH  async-load data, constant AD_VALUE.
- aload  output  1  async-load control.
- en  output  1  enable control.
- busy  output  1  high while the sequence is running (PRE through RUN).
- done  output  1  one-cycle pulse at sequence end.
- phase  output  3  current state encoding.

Behaviour:
- Reset (rst_n low) takes effect immediately, without waiting for clk, including mid-sequence. Reset values:
  - state = IDLE, phase = 0
  - d = 0, ad = AD_VALUE
  - aload = 0, en = 0, busy = 0, done = 0
  - counter cleared
- State encodings: IDLE=0, PRE=1, LOAD0=2, GAP=3, LOAD1=4, RUN=5, DONE=6. Value 7 is unreachable; if ever entered, go to IDLE next edge.
- IDLE → PRE on an edge with start=1.
- On entry to each timed phase, the counter loads T_x-1 and decrements each cycle. The phase exits on the edge where the counter is 0.
- Timed-phase order:
  - PRE (T_PRE) → LOAD0 (T_LOAD) → GAP (T_GAP) → LOAD1 (T_LOAD) → RUN (T_RUN) → DONE.
- DONE lasts exactly 1 cycle, then → IDLE.
- Output decode (registered; valid in the same cycle as phase):
  - aload = 1 only in LOAD0 and LOAD1.
  - en = 1 in LOAD1 and RUN.
  - busy = 1 in PRE through RUN.
  - done = 1 only in DONE.
- d updates every edge while the next state is in PRE..RUN; it holds its value in IDLE and DONE. Default update: d <= ~d.
- ad is constant AD_VALUE at all times after reset.
- start is ignored outside IDLE; this includes start during DONE.
- If start is held high continuously, runs repeat back-to-back with exactly one IDLE cycle between DONE and the next PRE.
- Busy length per run is T_PRE + 2*T_LOAD + T_GAP + T_RUN cycles; with defaults this is 11.

Optional Feature:
- Macro: ALDSEQ_LFSR_EN.
- When defined:
  - d is a Fibonacci LFSR: next d = {d[WIDTH-2:0], d[WIDTH-1]^d[WIDTH-2]}.
  - Reset value of d is all ones, so the LFSR never locks up.
  - It advances under the same conditions as the default toggle.
- When undefined:
  - d toggles via d <= ~d.
  - Reset value of d is 0.
- All other behaviour is identical with or without the macro.

Test Plan:
- Reset: rst_n=0 with clk running → d=0000, ad=1010, aload=0, en=0, busy=0, done=0, phase=0. Outputs hold while rst_n=0.
- Single run (defaults): start=1 for one edge (call it edge 0) → phase per edge 1,1,2,3,3,4,5,5,5,5,5,6,0.
  - aload high after edges 3 and 6; en high after edges 6–11.
  - busy high for 11 cycles; done high for exactly one cycle after edge 12.
- Data (no macro): during the single run, d alternates 1111, 0000, ... each busy edge. d is frozen at its last value in DONE and IDLE.
- Continuous start: start held at 1 for 30 cycles → second PRE begins exactly 2 edges after first done rises. start during DONE does not shorten or extend the IDLE cycle.
- Async reset mid-RUN: drop rst_n between clk edges during phase 5 → all outputs reach reset values before the next clk edge. After release with start=0, phase stays 0.
- ALDSEQ_LFSR_EN defined: after reset d=1111. During a run, successive d values are 1110, 1100, 1000, 0001, 0010, ... with no 0000 ever observed.
